// File: rtl/tri_toggle_pkg.sv
// Shared types and helpers for the three-channel toggle stimulus generator.
// State encoding, default widths and the half-period clamp live here.
package tri_toggle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int CW_DEF    = 8;
    localparam int RUN_W_DEF = 16;

    // A programmed half-period of 0 behaves like 1.
    function automatic logic [31:0] eff_half(input logic [31:0] h);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/tri_toggle_stim_if.sv
// Control/status bundle between a run controller and tri_toggle_stim.
// The master programs and launches runs; the slave drives the stimulus.
interface tri_toggle_stim_if #(
    parameter int CW    = 8,
    parameter int RUN_W = 16
);

    logic             start;
    logic             stop;
    logic [CW-1:0]    half_a;
    logic [CW-1:0]    half_b;
    logic [CW-1:0]    half_c;
    logic [RUN_W-1:0] run_len;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic [RUN_W-1:0] cyc_cnt;

    modport master (
        output start, stop,
        output half_a, half_b, half_c,
        output run_len,
        input  a, b, c,
        input  busy, done, cyc_cnt
    );

    modport slave (
        input  start, stop,
        input  half_a, half_b, half_c,
        input  run_len,
        output a, b, c,
        output busy, done, cyc_cnt
    );

endinterface

// File: rtl/tri_toggle_stim_chan.sv
// One stimulus channel: half-period counter plus its output flop.
// Clear wins over enable; the output holds whenever enable is low.
module toggle_chan
    import tri_toggle_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] half,
    output logic          q
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] last;
    logic          q_q;
    logic          q_d;

    assign last = CW'(eff_half(32'(half)) - 32'd1);

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (clr) begin
            cnt_d = '0;
            q_d   = 1'b0;
        end else if (en) begin
            if (cnt_q == last) begin
                cnt_d = '0;
                q_d   = ~q_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tri_toggle_stim.sv
// Three-channel toggle stimulus generator with run-length control.
// Holds the run FSM, latched configuration and the run cycle counter.
module tri_toggle_stim
    import tri_toggle_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    tri_toggle_stim_if.slave bus
);

    state_e           state_q;
    state_e           state_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic [RUN_W-1:0] cyc_q;
    logic [RUN_W-1:0] cyc_d;
    logic [RUN_W-1:0] cyc_nxt;
    logic [RUN_W-1:0] len_q;
    logic [RUN_W-1:0] len_d;
    logic [CW-1:0]    ha_q;
    logic [CW-1:0]    ha_d;
    logic [CW-1:0]    hb_q;
    logic [CW-1:0]    hb_d;
    logic [CW-1:0]    hc_q;
    logic [CW-1:0]    hc_d;
    logic             ch_clr;
    logic             ch_en;
    logic             a_w;
    logic             b_w;
    logic             c_w;

    assign cyc_nxt = cyc_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cyc_d   = cyc_q;
        len_d   = len_q;
        ha_d    = ha_q;
        hb_d    = hb_q;
        hc_d    = hc_q;
        ch_clr  = 1'b0;
        ch_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cyc_d   = '0;
                    ch_clr  = 1'b1;
                    len_d   = bus.run_len;
                    ha_d    = bus.half_a;
                    hb_d    = bus.half_b;
                    hc_d    = bus.half_c;
                end
            end
            RUN: begin
                // Abort beats completion: no toggle, no count, no done.
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ch_en = 1'b1;
                    cyc_d = cyc_nxt;
                    if (len_q != '0 && cyc_nxt == len_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
            len_q   <= '0;
            ha_q    <= '0;
            hb_q    <= '0;
            hc_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
            len_q   <= len_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
            hc_q    <= hc_d;
        end
    end

    toggle_chan #(.CW(CW)) u_chan_a (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (ch_clr),
        .en    (ch_en),
        .half  (ha_q),
        .q     (a_w)
    );

    toggle_chan #(.CW(CW)) u_chan_b (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (ch_clr),
        .en    (ch_en),
        .half  (hb_q),
        .q     (b_w)
    );

    toggle_chan #(.CW(CW)) u_chan_c (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (ch_clr),
        .en    (ch_en),
        .half  (hc_q),
        .q     (c_w)
    );

    assign bus.a       = a_w;
    assign bus.b       = b_w;
    assign bus.c       = c_w;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cyc_cnt = cyc_q;

endmodule

// File: tb/tb_tri_toggle_stim.sv
// Directed bench for tri_toggle_stim: expected outputs are derived in
// closed form from the edge index and queued before each clock edge.
module tb_tri_toggle_stim;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [20:0] exp_q[$];

    tri_toggle_stim_if #(.CW(8), .RUN_W(16)) m ();
    tri_toggle_stim_if #(.CW(8), .RUN_W(4))  n ();

    tri_toggle_stim #(.CW(8), .RUN_W(16)) u_main (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (m)
    );

    tri_toggle_stim #(.CW(8), .RUN_W(4)) u_narrow (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic tog(input int k, input int h);
        int e;
        e = (h == 0) ? 1 : h;
        return ((k / e) % 2) == 1;
    endfunction

    function automatic logic [20:0] mk(input logic a, input logic b,
                                       input logic c, input logic bz,
                                       input logic dn, input int cy);
        return {a, b, c, bz, dn, 16'(cy)};
    endfunction

    // Expected {a,b,c,busy,done,cyc} after edge k of a run started at edge 0.
    function automatic logic [20:0] exp_run(input int k, input int ha,
                                            input int hb, input int hc,
                                            input int len);
        int t;
        t = (len != 0 && k > len) ? len : k;
        return mk(tog(t, ha), tog(t, hb), tog(t, hc),
                  (len == 0) || (k < len), (len != 0) && (k == len), t);
    endfunction

    function automatic logic [20:0] obs(input bit nar);
        if (nar)
            return {n.a, n.b, n.c, n.busy, n.done, 12'b0, n.cyc_cnt};
        return {m.a, m.b, m.c, m.busy, m.done, m.cyc_cnt};
    endfunction

    task automatic chk(input logic [20:0] got, input string tag);
        logic [20:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
    endtask

    task automatic step(input logic [20:0] e, input bit nar,
                        input string tag);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk(obs(nar), tag);
    endtask

    task automatic drv(input bit nar, input logic st, input logic sp,
                       input int ha, input int hb, input int hc,
                       input int len);
        if (nar) begin
            n.start   = st;
            n.stop    = sp;
            n.half_a  = 8'(ha);
            n.half_b  = 8'(hb);
            n.half_c  = 8'(hc);
            n.run_len = 4'(len);
        end else begin
            m.start   = st;
            m.stop    = sp;
            m.half_a  = 8'(ha);
            m.half_b  = 8'(hb);
            m.half_c  = 8'(hc);
            m.run_len = 16'(len);
        end
    endtask

    initial begin
        int   acnt;
        int   first_y;
        logic pa;
        logic [20:0] hold;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        #2;
        exp_q.push_back(21'd0);
        chk(obs(0), "reset_main");
        exp_q.push_back(21'd0);
        chk(obs(1), "reset_narrow");
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // half 10/55/75, run 300
        drv(0, 1, 0, 10, 55, 75, 300);
        step(exp_run(0, 10, 55, 75, 300), 0, "t1_edge0");
        drv(0, 0, 0, 10, 55, 75, 300);
        acnt    = 0;
        first_y = -1;
        pa      = 1'b0;
        for (int k = 1; k <= 303; k++) begin
            step(exp_run(k, 10, 55, 75, 300), 0, "t1_run");
            if (k <= 300 && m.a !== pa) acnt++;
            pa = m.a;
            if (first_y < 0 && (m.a & m.b & m.c)) first_y = k;
        end
        exp_q.push_back(21'(30));
        chk(21'(acnt), "t1_a_toggles");
        exp_q.push_back(21'(75));
        chk(21'(first_y), "t1_first_y");

        // half_a=0 behaves like 1
        drv(0, 1, 0, 0, 1, 3, 8);
        step(exp_run(0, 0, 1, 3, 8), 0, "t2_edge0");
        drv(0, 0, 0, 0, 1, 3, 8);
        for (int k = 1; k <= 10; k++)
            step(exp_run(k, 0, 1, 3, 8), 0, "t2_run");

        // free-run aborted by stop at edge 100
        drv(0, 1, 1, 7, 13, 0, 0);
        step(exp_run(0, 7, 13, 0, 0), 0, "t3_edge0");
        drv(0, 0, 0, 7, 13, 0, 0);
        for (int k = 1; k <= 99; k++)
            step(exp_run(k, 7, 13, 0, 0), 0, "t3_run");
        drv(0, 0, 1, 7, 13, 0, 0);
        hold = mk(tog(99, 7), tog(99, 13), tog(99, 0), 0, 0, 99);
        step(hold, 0, "t3_stop");
        step(hold, 0, "t3_stop_idle");
        drv(0, 0, 0, 7, 13, 0, 0);
        step(hold, 0, "t3_hold");

        // async reset between edges 40 and 41
        drv(0, 1, 0, 4, 5, 6, 200);
        step(exp_run(0, 4, 5, 6, 200), 0, "t4_edge0");
        drv(0, 0, 0, 4, 5, 6, 200);
        for (int k = 1; k <= 40; k++)
            step(exp_run(k, 4, 5, 6, 200), 0, "t4_run");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(21'd0);
        chk(obs(0), "t4_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drv(0, 1, 0, 3, 4, 5, 12);
        step(exp_run(0, 3, 4, 5, 12), 0, "t4_restart0");
        drv(0, 0, 0, 3, 4, 5, 12);
        for (int k = 1; k <= 13; k++)
            step(exp_run(k, 3, 4, 5, 12), 0, "t4_restart");

        // start re-pulse with new half_a mid-run is ignored
        drv(0, 1, 0, 10, 20, 30, 50);
        step(exp_run(0, 10, 20, 30, 50), 0, "t5_edge0");
        drv(0, 0, 0, 10, 20, 30, 50);
        for (int k = 1; k <= 19; k++)
            step(exp_run(k, 10, 20, 30, 50), 0, "t5_run");
        drv(0, 1, 0, 3, 20, 30, 50);
        step(exp_run(20, 10, 20, 30, 50), 0, "t5_restart_ign");
        drv(0, 0, 0, 3, 20, 30, 50);
        for (int k = 21; k <= 52; k++)
            step(exp_run(k, 10, 20, 30, 50), 0, "t5_run2");

        // 4-bit cycle counter wraps in free-run
        drv(1, 1, 0, 2, 3, 0, 0);
        step(mk(0, 0, 0, 1, 0, 0), 1, "t6_edge0");
        drv(1, 0, 0, 2, 3, 0, 0);
        for (int k = 1; k <= 20; k++)
            step(mk(tog(k, 2), tog(k, 3), tog(k, 0), 1, 0, k % 16),
                 1, "t6_wrap");
        drv(1, 0, 1, 2, 3, 0, 0);
        step(mk(tog(20, 2), tog(20, 3), tog(20, 0), 0, 0, 4),
             1, "t6_stop");
        drv(1, 0, 0, 2, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
